pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Controls a PLLE2_BASE: drives its RST pin, consumes its LOCKED output, and generates ordered resets for the domains it clocks.
//  Holds the PLL in reset, waits for lock with timeout/retry, debounces lock, then releases NUM_RST downstream resets one stage at a time.
//  Re-runs the sequence on lock loss or on force_i.
//  clk_i is the free-running PLL reference clock (100MHz), never a PLL output.
// PARAMETERS
//  PLL_RST_CYCLES  16     cycles pll_rst_o is held high per attempt (>=1)
//  LOCK_TIMEOUT    65535  cycles to wait for lock before retrying (>=2)
//  LOCK_STABLE     1024   consecutive synchronized-lock cycles required before release (>=1)
//  STAGE_DELAY     64     cycles between successive rst_o deassertions (>=1)
//  NUM_RST         3      number of downstream reset outputs (1..8)
//  CNT_W           16     shared counter width; must hold max(all cycle params)
// PORTS
//  clk_i            in   1        free-running reference clock
//  rst_n_i          in   1        synchronous active-low reset
//  pll_locked_i     in   1        PLL LOCKED (asynchronous to clk_i)
//  force_i          in   1        request full re-sequence (level, sampled each cycle)
//  pll_rst_o        out  1        to PLL RST, active high
//  rst_o            out  NUM_RST  downstream resets, active high; bit 0 released first
//  ready_o          out  1        all resets released, PLL locked
//  relock_count_o   out  8        lock-loss events, saturates at 255
//  timeout_count_o  out  8        lock-timeout retries, saturates at 255
//  state_o          out  3        current state encoding (debug)
// BEHAVIOUR
//  Reset (rst_n_i=0 at a clk_i edge): state=PLL_RST, cnt=0, pll_rst_o=1, rst_o=all 1s, ready_o=0,
//   both counts=0, synchronizer flops=0.
//  Synchronizer: pll_locked_i passes through 2 flops -> lock_s; 2-cycle latency. The FSM uses only lock_s.
//  All outputs are registered. cnt clears on every state entry.
//  PLL_RST: pll_rst_o=1 for exactly PLL_RST_CYCLES cycles, then -> WAIT_LOCK. force_i ignored here.
//  WAIT_LOCK: pll_rst_o=0.
//   lock_s=1 -> STABLE.
//   Else, when cnt reaches LOCK_TIMEOUT-1 -> timeout_count_o+1 (saturating), -> PLL_RST.
//  STABLE: lock_s=0 -> WAIT_LOCK with a fresh timeout count.
//   LOCK_STABLE consecutive cycles of lock_s=1 -> RELEASE.
//  RELEASE: stage k = 0..NUM_RST-1; rst_o[k] deasserts STAGE_DELAY cycles after the previous stage
//   (stage 0: STAGE_DELAY cycles after RELEASE entry). Once deasserted, a bit stays low until the next abort.
//   After rst_o[NUM_RST-1] deasserts -> RUN; ready_o=1 on the same edge as the last bit.
//  RUN: hold. Outputs: rst_o=0, ready_o=1, pll_rst_o=0.
//  Abort (lock_s=0 in RELEASE or RUN): on the next edge rst_o=all 1s, ready_o=0,
//   relock_count_o+1 (saturating), -> PLL_RST. Latency from a pll_locked_i fall to rst_o assert is 3 cycles.
//  force_i=1 in WAIT_LOCK/STABLE/RELEASE/RUN: same as abort, but counts are unchanged.
//   force_i has priority over a simultaneous lock loss, so no count increment.
//  force_i held high: the sequence restarts repeatedly and never leaves PLL_RST->WAIT_LOCK,
//   because force_i aborts WAIT_LOCK.
//  Counters saturate at 255 and never wrap. cnt never exceeds its state's terminal value.
//  rst_n_i asserted mid-sequence: immediate return to reset values, counts included.
// STRUCTURE
//  Package pll_seq_pkg: state localparams (PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4)
//   and the SAT8 max constant.
//  Sub-module pll_seq_sync2: 2-flop synchronizer, reset to 0 by rst_n_i, ASYNC_REG attributes on both flops.
//  Top: one FSM, one CNT_W counter, one stage index ($clog2(NUM_RST+1) bits), two 8-bit saturating counters.
// TESTING (PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, STAGE_DELAY=4, NUM_RST=3)
//  1 Reset release, locked_i raised 10 cycles later -> pll_rst_o high exactly 4 cycles;
//    rst_o[0],[1],[2] fall 4 cycles apart; ready_o rises with rst_o[2]; counts=0.
//  2 locked_i held 0 -> pll_rst_o pulses 4 cycles every 36 cycles; timeout_count_o 1,2,3...;
//    saturates at 255 after 255 retries.
//  3 locked_i glitches low 1 cycle during STABLE -> back to WAIT_LOCK, no release;
//    full 8-cycle stability is required afterwards.
//  4 locked_i falls in RUN -> rst_o=3'b111 and ready_o=0 exactly 3 cycles later; relock_count_o=1;
//    sequence repeats.
//  5 force_i pulsed in RELEASE after rst_o[0] release -> all resets reassert next cycle; counts unchanged;
//    a full re-sequence follows.
//  6 rst_n_i pulsed low in RUN with relock_count_o=5 -> all outputs at reset values next edge;
//    counts=0; sequence restarts.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Package: pll_seq_pkg
// Purpose: shared definitions for the PLL reset sequencer: the FSM state
//          encoding (also exported on state_o for debug), the saturation
//          limit of the 8-bit event counters and a saturating increment.
// Ports:   none (package)
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam logic [7:0] SAT8 = 8'hFF;

    // Event counters stick at their maximum rather than wrapping, so a
    // large value always means "many events", never "few after a wrap".
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == SAT8) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/pll_seq_sync2.sv
// Module: pll_seq_sync2
// Purpose: two-flop synchronizer bringing the PLL LOCKED pin (asynchronous
//          to the reference clock) into the clk domain.
// Ports:
//   clk    in  1  reference clock
//   rst_n  in  1  synchronous active-low reset, clears both flops
//   d      in  1  asynchronous input
//   q      out 1  synchronized output, two cycles of latency
module pll_seq_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic meta;
    (* ASYNC_REG = "TRUE" *) logic sync;

    // Both flops carry ASYNC_REG so placement keeps them adjacent and the
    // first stage gets a full cycle to resolve metastability.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Module: pll_reset_sequencer
// Purpose: drives a PLL's RST pin, waits for LOCKED with timeout and retry,
//          debounces lock, then releases NUM_RST downstream resets one stage
//          at a time. Lock loss or force_i restarts the whole sequence.
// Ports:
//   clk_i            in  1        free-running reference clock (not a PLL output)
//   rst_n_i          in  1        synchronous active-low reset
//   pll_locked_i     in  1        PLL LOCKED, asynchronous to clk_i
//   force_i          in  1        level request for a full re-sequence
//   pll_rst_o        out 1        PLL RST, active high
//   rst_o            out NUM_RST  downstream resets, active high, bit 0 first
//   ready_o          out 1        all resets released and PLL locked
//   relock_count_o   out 8        lock-loss events, saturating
//   timeout_count_o  out 8        lock-timeout retries, saturating
//   state_o          out 3        current FSM state (debug)
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int LOCK_STABLE    = 1024,
    parameter int STAGE_DELAY    = 64,
    parameter int NUM_RST        = 3,
    parameter int CNT_W          = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               pll_locked_i,
    input  logic               force_i,
    output logic               pll_rst_o,
    output logic [NUM_RST-1:0] rst_o,
    output logic               ready_o,
    output logic [7:0]         relock_count_o,
    output logic [7:0]         timeout_count_o,
    output logic [2:0]         state_o
);

    localparam int STAGE_W = $clog2(NUM_RST + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]   STAGE_LAST   = CNT_W'(STAGE_DELAY - 1);
    localparam logic [STAGE_W-1:0] FINAL_STAGE  = STAGE_W'(NUM_RST - 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [STAGE_W-1:0]   stage;
    logic [STAGE_W-1:0]   stage_next;
    logic [NUM_RST-1:0]   rst_next;
    logic [7:0]           relock_next;
    logic [7:0]           timeout_next;
    logic                 restart;
    logic                 lock_s;

    pll_seq_sync2 u_lock_sync (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .d     (pll_locked_i),
        .q     (lock_s)
    );

    // Next-state logic. Every abort path funnels through 'restart' so the
    // re-entry into PLL_RST is identical whether it came from a timeout,
    // lock loss or force. force_i is checked first so a simultaneous lock
    // loss or timeout is not counted.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + CNT_W'(1);
        stage_next   = stage;
        rst_next     = rst_o;
        relock_next  = relock_count_o;
        timeout_next = timeout_count_o;
        restart      = 1'b0;

        case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end
            end
            WAIT_LOCK: begin
                if (force_i) begin
                    restart = 1'b1;
                end else if (lock_s) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout_next = sat_inc(timeout_count_o);
                    restart      = 1'b1;
                end
            end
            STABLE: begin
                if (force_i) begin
                    restart = 1'b1;
                end else if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_next = RELEASE;
                    cnt_next   = '0;
                    stage_next = '0;
                end
            end
            RELEASE: begin
                if (force_i) begin
                    restart = 1'b1;
                end else if (!lock_s) begin
                    relock_next = sat_inc(relock_count_o);
                    restart     = 1'b1;
                end else if (cnt == STAGE_LAST) begin
                    cnt_next   = '0;
                    stage_next = stage + STAGE_W'(1);
                    for (int k = 0; k < NUM_RST; k++) begin
                        if (stage == STAGE_W'(k)) begin
                            rst_next[k] = 1'b0;
                        end
                    end
                    if (stage == FINAL_STAGE) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                cnt_next = '0;
                if (force_i) begin
                    restart = 1'b1;
                end else if (!lock_s) begin
                    relock_next = sat_inc(relock_count_o);
                    restart     = 1'b1;
                end
            end
            default: begin
                restart = 1'b1;
            end
        endcase

        if (restart) begin
            state_next = PLL_RST;
            cnt_next   = '0;
            stage_next = '0;
            rst_next   = '1;
        end
    end

    // State and output registers. pll_rst_o and ready_o are decoded from
    // the next state so they change on the same edge as the state itself.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state           <= PLL_RST;
            cnt             <= '0;
            stage           <= '0;
            pll_rst_o       <= 1'b1;
            rst_o           <= '1;
            ready_o         <= 1'b0;
            relock_count_o  <= 8'd0;
            timeout_count_o <= 8'd0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            stage           <= stage_next;
            pll_rst_o       <= (state_next == PLL_RST);
            rst_o           <= rst_next;
            ready_o         <= (state_next == RUN);
            relock_count_o  <= relock_next;
            timeout_count_o <= timeout_next;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench: tb_pll_reset_sequencer
// Purpose: directed scenarios plus randomized stimulus for pll_reset_sequencer,
//          checked every cycle against an elapsed-time model of the sequence.
module tb_pll_reset_sequencer;

    localparam int P_RST = 4;
    localparam int P_TO  = 32;
    localparam int P_STB = 8;
    localparam int P_SD  = 4;
    localparam int N_RST = 3;

    // Phase numbers follow the documented state_o encoding.
    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STAB = 2;
    localparam int PH_REL  = 3;
    localparam int PH_RUN  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic locked = 1'b0;
    logic force_r = 1'b0;
    logic check_en = 1'b0;

    logic             pll_rst_o;
    logic [N_RST-1:0] rst_o;
    logic             ready_o;
    logic [7:0]       relock_count_o;
    logic [7:0]       timeout_count_o;
    logic [2:0]       state_o;

    int n_checks = 0;
    int n_fail = 0;

    int m_phase = PH_RST;
    int m_elapsed = 0;
    int m_relock = 0;
    int m_timeout = 0;
    logic m_ls1 = 1'b0;
    logic m_ls2 = 1'b0;

    int hi, f0, f1, f2, rdy, rises, saw_wait;
    int rise_t[4];
    logic prev;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (P_RST),
        .LOCK_TIMEOUT   (P_TO),
        .LOCK_STABLE    (P_STB),
        .STAGE_DELAY    (P_SD),
        .NUM_RST        (N_RST),
        .CNT_W          (16)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .pll_locked_i    (locked),
        .force_i         (force_r),
        .pll_rst_o       (pll_rst_o),
        .rst_o           (rst_o),
        .ready_o         (ready_o),
        .relock_count_o  (relock_count_o),
        .timeout_count_o (timeout_count_o),
        .state_o         (state_o)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic f);
        rst_n   = r;
        locked  = l;
        force_r = f;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic enterPhase(input int p);
        m_phase   = p;
        m_elapsed = 0;
    endtask

    // One clock edge of the reference behaviour, in terms of time spent in
    // each phase rather than any particular counter arrangement.
    task automatic modelStep(input logic lock_s);
        int next_e;
        next_e = m_elapsed + 1;
        case (m_phase)
            PH_RST: begin
                if (next_e == P_RST) enterPhase(PH_WAIT);
                else m_elapsed = next_e;
            end
            PH_WAIT: begin
                if (force_r) enterPhase(PH_RST);
                else if (lock_s) enterPhase(PH_STAB);
                else if (next_e == P_TO) begin
                    m_timeout = (m_timeout < 255) ? m_timeout + 1 : 255;
                    enterPhase(PH_RST);
                end else m_elapsed = next_e;
            end
            PH_STAB: begin
                if (force_r) enterPhase(PH_RST);
                else if (!lock_s) enterPhase(PH_WAIT);
                else if (next_e == P_STB) enterPhase(PH_REL);
                else m_elapsed = next_e;
            end
            default: begin
                if (force_r) enterPhase(PH_RST);
                else if (!lock_s) begin
                    m_relock = (m_relock < 255) ? m_relock + 1 : 255;
                    enterPhase(PH_RST);
                end else if (m_phase == PH_REL) begin
                    if (next_e == N_RST * P_SD) enterPhase(PH_RUN);
                    else m_elapsed = next_e;
                end
            end
        endcase
    endtask

    // In RELEASE the number of bits already released is simply the elapsed
    // time divided by the stage delay.
    function automatic logic [23:0] modelOut();
        logic [2:0] r;
        int released;
        released = 0;
        if (m_phase == PH_REL) begin
            released = m_elapsed / P_SD;
            r = 3'(7 << released);
        end else if (m_phase == PH_RUN) begin
            r = 3'b000;
        end else begin
            r = 3'b111;
        end
        return {(m_phase == PH_RST), r, (m_phase == PH_RUN), 8'(m_relock), 8'(m_timeout), 3'(m_phase)};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            enterPhase(PH_RST);
            m_relock  = 0;
            m_timeout = 0;
            m_ls1     = 1'b0;
            m_ls2     = 1'b0;
        end else begin
            modelStep(m_ls2);
            m_ls2 = m_ls1;
            m_ls1 = locked;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cycle model",
                        {8'd0, pll_rst_o, rst_o, ready_o, relock_count_o, timeout_count_o, state_o},
                        {8'd0, modelOut()});
        end
    end

    initial begin
        int r;

        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(3);
        check_en = 1'b1;
        checkOutput("reset pll_rst", pll_rst_o, 1);
        checkOutput("reset rst_o", rst_o, 3'b111);
        checkOutput("reset ready", ready_o, 0);
        checkOutput("reset relock", relock_count_o, 0);
        checkOutput("reset timeout", timeout_count_o, 0);
        checkOutput("reset state", state_o, 0);

        // Scenario 1: clean bring-up, lock 10 cycles after release
        $display("[TB] scenario 1: clean bring-up");
        applyStimulus(1'b1, 1'b0, 1'b0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (pll_rst_o) hi++;
            tick();
        end
        checkOutput("t1 pll_rst width", hi, 4);
        applyStimulus(1'b1, 1'b1, 1'b0);
        f0 = -1; f1 = -1; f2 = -1; rdy = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (f0 < 0 && !rst_o[0]) f0 = i;
            if (f1 < 0 && !rst_o[1]) f1 = i;
            if (f2 < 0 && !rst_o[2]) f2 = i;
            if (rdy < 0 && ready_o) rdy = i;
        end
        checkOutput("t1 rst0 fall after lock", f0, 15);
        checkOutput("t1 rst1 gap", f1 - f0, 4);
        checkOutput("t1 rst2 gap", f2 - f1, 4);
        checkOutput("t1 ready with rst2", rdy, f2);
        checkOutput("t1 counts", {relock_count_o, timeout_count_o}, 0);

        // Scenario 2: no lock at all, retries until the counter saturates
        $display("[TB] scenario 2: lock timeout retries");
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        rises = 0;
        prev = pll_rst_o;
        for (int i = 1; i <= 40 * 260 && rises < 258; i++) begin
            tick();
            if (pll_rst_o && !prev) begin
                rises++;
                if (rises <= 3) begin
                    rise_t[rises] = i;
                    checkOutput("t2 timeout count at retry", timeout_count_o, rises);
                end
            end
            prev = pll_rst_o;
        end
        checkOutput("t2 first retry time", rise_t[1], 36);
        checkOutput("t2 retry period", rise_t[3] - rise_t[2], 36);
        checkOutput("t2 retries seen", rises, 258);
        checkOutput("t2 timeout saturated", timeout_count_o, 255);

        // Scenario 3: one-cycle lock glitch during STABLE
        $display("[TB] scenario 3: lock glitch in STABLE");
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 60 && state_o != 3'd2; i++) tick();
        checkOutput("t3 reached STABLE", state_o, 2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        f0 = -1;
        saw_wait = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (state_o == 3'd1) saw_wait = 1;
            if (f0 < 0 && !rst_o[0]) f0 = i;
        end
        checkOutput("t3 glitch returns to WAIT_LOCK", saw_wait, 1);
        checkOutput("t3 release after full stability", f0, 15);

        // Scenario 4: lock loss while running
        $display("[TB] scenario 4: lock loss in RUN");
        checkOutput("t4 running before loss", ready_o, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(2);
        checkOutput("t4 outputs at +2", {rst_o, ready_o}, 4'b0001);
        tick();
        checkOutput("t4 outputs at +3", {rst_o, ready_o}, 4'b1110);
        checkOutput("t4 relock count", relock_count_o, 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 100 && !ready_o; i++) tick();
        checkOutput("t4 resequence ready", ready_o, 1);

        // Scenario 5: force during RELEASE
        $display("[TB] scenario 5: force in RELEASE");
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t5 force from RUN", {rst_o, ready_o}, 4'b1110);
        for (int i = 0; i < 100 && rst_o != 3'b110; i++) tick();
        checkOutput("t5 reached first release", rst_o, 3'b110);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t5 force reasserts", rst_o, 3'b111);
        checkOutput("t5 counts unchanged", {relock_count_o, timeout_count_o}, 16'h0100);
        for (int i = 0; i < 100 && !ready_o; i++) tick();
        checkOutput("t5 resequence ready", ready_o, 1);

        // Scenario 6: reset in RUN after several lock losses
        $display("[TB] scenario 6: reset in RUN");
        repeat (4) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            tick(4);
            applyStimulus(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 100 && !ready_o; i++) tick();
        end
        checkOutput("t6 relock count", relock_count_o, 5);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("t6 reset values",
                    {pll_rst_o, rst_o, ready_o, relock_count_o, timeout_count_o, state_o},
                    {1'b1, 3'b111, 1'b0, 8'd0, 8'd0, 3'd0});
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 100 && !ready_o; i++) tick();
        checkOutput("t6 restart ready", ready_o, 1);

        // Randomized traffic: lock toggling, force pulses, occasional reset
        $display("[TB] randomized phase");
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 20) locked = ~locked;
            force_r = (r >= 20 && r < 30);
            rst_n = !(r >= 996);
            tick();
        end

        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
